alu_issue_ctrl: RTL and testbench

Initiator-side front end for the two-stage pipelined ALU (op/a/b/vld in, out/out_vld two cycles later). It accepts tagged operation requests over a ready/valid interface and drives the ALU's input port. It tracks in-flight operations in a tag pipeline aligned to the ALU latency, and returns results with their tags through a credit-protected response FIFO. The ALU cannot stall, so this block never issues an operation unless response storage is guaranteed.

---
 rtl/alu_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Request front end for the two-stage pipelined ALU: issues tagged ops, tracks them
// in a latency-matched tag pipeline and returns results through a credit-protected FIFO.
module alu_issue_ctrl #(
  parameter int WIDTH      = 6,
  parameter int TAG_W      = 4,
  parameter int RESP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_vld,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_out_vld,
  output logic             resp_vld,
  input  logic             resp_rdy,
  output logic [WIDTH-1:0] resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic             proto_err
);

  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  // Handshakes: a transfer happens on a clock edge where both valid and ready are
  // high; valid never depends on ready, and req_rdy depends on registered state only.
  logic             accept;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] committed;

  logic             s1_vld_q, s2_vld_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
  logic             s1_err_q, s2_err_q;

  entry_t           mem_q [RESP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             proto_err_q;

  // Every accepted op owns a FIFO slot from issue until its response is popped.
  assign committed = count_q + CNT_W'(s1_vld_q) + CNT_W'(s2_vld_q);
  assign req_rdy   = !rst && (committed < CNT_W'(RESP_DEPTH));
  assign accept    = req_vld && req_rdy;

  assign alu_vld = accept;
  assign alu_a   = req_a;
  assign alu_b   = req_b;
  assign alu_op  = (req_op == 2'd3) ? 2'd0 : req_op;

  assign push = s2_vld_q;
  assign pop  = resp_vld && resp_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_tag_q <= '0;
      s1_err_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_tag_q <= '0;
      s2_err_q <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      s1_tag_q <= req_tag;
      s1_err_q <= (req_op == 2'd3);
      s2_vld_q <= s1_vld_q;
      s2_tag_q <= s1_tag_q;
      s2_err_q <= s1_err_q;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RESP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{data: alu_out, tag: s2_tag_q, err: s2_err_q};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // The ALU's result valid must track the tag pipeline exactly; any slip is latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err_q <= 1'b0;
    end else if (alu_out_vld != s2_vld_q) begin
      proto_err_q <= 1'b1;
    end
  end

  assign resp_vld  = (count_q != '0);
  assign resp_data = mem_q[rd_ptr_q].data;
  assign resp_tag  = mem_q[rd_ptr_q].tag;
  assign resp_err  = mem_q[rd_ptr_q].err;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural two-stage ALU, directed requests, expected
// responses queued on acceptance and popped by an independent response monitor.
module tb_alu_issue_ctrl;

  localparam int WIDTH      = 6;
  localparam int TAG_W      = 4;
  localparam int RESP_DEPTH = 4;
  localparam int W          = WIDTH + TAG_W + 1;

  logic             clk;
  logic             rst;
  logic             req_vld;
  logic             req_rdy;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic             alu_vld;
  logic [WIDTH-1:0] alu_out;
  logic             alu_out_vld;
  logic             resp_vld;
  logic             resp_rdy;
  logic [WIDTH-1:0] resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_err;
  logic             proto_err;

  logic [W-1:0] exp_q[$];
  int           pop_cyc_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;

  alu_issue_ctrl #(.WIDTH(WIDTH), .TAG_W(TAG_W), .RESP_DEPTH(RESP_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_vld(alu_vld),
    .alu_out(alu_out), .alu_out_vld(alu_out_vld),
    .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err), .proto_err(proto_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- ALU model (two register stages, shares rst) ----------------
  logic             inject;
  logic             p1_vld, p2_vld;
  logic [1:0]       p1_op;
  logic [WIDTH-1:0] p1_a, p1_b, p2_res;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      2'd1:    return a + b;
      2'd2:    return a - b;
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_vld <= 1'b0;
      p1_op  <= '0;
      p1_a   <= '0;
      p1_b   <= '0;
      p2_vld <= 1'b0;
      p2_res <= '0;
    end else begin
      p1_vld <= alu_vld;
      p1_op  <= alu_op;
      p1_a   <= alu_a;
      p1_b   <= alu_b;
      p2_vld <= p1_vld;
      p2_res <= alu_fn(p1_op, p1_a, p1_b);
    end
  end

  assign alu_out     = p2_res;
  assign alu_out_vld = p2_vld | inject;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                      input logic [WIDTH-1:0] exp_d, output int waited);
    req_vld = 1'b1;
    req_op  = op;
    req_a   = a;
    req_b   = b;
    req_tag = tag;
    waited  = 0;
    forever begin
      @(negedge clk);
      if (req_rdy) break;
      waited++;
      if (waited > 60) break;
    end
    check("send_accepted", 32'(waited <= 60), 32'd1);
    if (waited <= 60) exp_q.push_back({exp_d, tag, (op == 2'd3)});
    @(posedge clk);
    #1;
    req_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitors ----------------
  logic [W-1:0] mon_e;

  always @(negedge clk) begin
    if (!rst && resp_vld && resp_rdy) begin
      pop_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("resp_unexpected", {resp_data, resp_tag, resp_err}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_data", 32'(resp_data), 32'(mon_e[W-1 -: WIDTH]));
        check("resp_tag",  32'(resp_tag),  32'(mon_e[TAG_W:1]));
        check("resp_err",  32'(resp_err),  32'(mon_e[0]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("alu_vld", 32'(alu_vld), 32'(req_vld && req_rdy));
      if (req_vld && req_rdy) begin
        check("alu_op", 32'(alu_op), (req_op == 2'd3) ? 32'd0 : 32'(req_op));
        check("alu_a",  32'(alu_a),  32'(req_a));
        check("alu_b",  32'(alu_b),  32'(req_b));
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    int stalls;
    int nacc;
    int bad;
    rst      = 1'b1;
    req_vld  = 1'b1;
    req_op   = 2'd1;
    req_a    = '0;
    req_b    = '0;
    req_tag  = '0;
    resp_rdy = 1'b0;
    inject   = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_req_rdy",   32'(req_rdy),   32'd0);
    check("rst_alu_vld",   32'(alu_vld),   32'd0);
    check("rst_resp_vld",  32'(resp_vld),  32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_resp_tag",  32'(resp_tag),  32'd0);
    check("rst_resp_err",  32'(resp_err),  32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    @(posedge clk);
    #1;
    req_vld  = 1'b0;
    rst      = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    check("post_rst_req_rdy", 32'(req_rdy), 32'd1);
    @(posedge clk);
    #1;

    // single add with wrap, three-cycle latency
    send(2'd1, 6'h3F, 6'h01, 4'd5, 6'h00, w);
    @(negedge clk);
    check("lat_cycle1_resp_vld", 32'(resp_vld), 32'd0);
    @(negedge clk);
    check("lat_cycle2_resp_vld", 32'(resp_vld), 32'd0);
    @(negedge clk);
    check("lat_cycle3_resp_vld", 32'(resp_vld), 32'd1);
    @(posedge clk);
    #1;
    wait_drain();

    // sub wrap, then nop
    send(2'd2, 6'h05, 6'h07, 4'd9, 6'h3E, w);
    send(2'd0, 6'h12, 6'h34, 4'd3, 6'h00, w);
    wait_drain();

    // back-to-back stream at full throughput
    pop_cyc_q.delete();
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      logic [WIDTH-1:0] ea, eb, es;
      ea = WIDTH'(i * 3);
      eb = WIDTH'(i * 2 + 5);
      es = WIDTH'(i * 5 + 5);
      send(2'd1, ea, eb, TAG_W'(i), es, w);
      stalls += w;
    end
    check("stream_stalls", 32'(stalls), 32'd0);
    wait_drain();
    check("stream_resp_count", 32'(pop_cyc_q.size()), 32'd16);
    if (pop_cyc_q.size() >= 16)
      check("stream_resp_span", 32'(pop_cyc_q[15] - pop_cyc_q[0]), 32'd15);

    // backpressure: only RESP_DEPTH accepted while resp_rdy is low
    resp_rdy = 1'b0;
    stalls   = 0;
    send(2'd1, 6'h01, 6'h02, 4'd12, 6'h03, w); stalls += w;
    send(2'd2, 6'h10, 6'h04, 4'd13, 6'h0C, w); stalls += w;
    send(2'd1, 6'h30, 6'h30, 4'd14, 6'h20, w); stalls += w;
    send(2'd0, 6'h0A, 6'h0B, 4'd15, 6'h00, w); stalls += w;
    check("bp_first4_stalls", 32'(stalls), 32'd0);
    req_vld = 1'b1;
    req_op  = 2'd1;
    req_a   = 6'h20;
    req_b   = 6'h21;
    req_tag = 4'd10;
    nacc    = 0;
    repeat (6) begin
      @(negedge clk);
      if (req_rdy) nacc++;
    end
    check("bp_held_rdy_cycles", 32'(nacc), 32'd0);
    check("bp_resp_vld", 32'(resp_vld), 32'd1);
    check("bp_stored", 32'(exp_q.size()), 32'd4);
    @(posedge clk);
    #1;
    resp_rdy = 1'b1;
    send(2'd1, 6'h20, 6'h21, 4'd10, 6'h01, w);
    send(2'd2, 6'h01, 6'h02, 4'd11, 6'h3F, w);
    wait_drain();

    // illegal op
    send(2'd3, 6'h10, 6'h01, 4'd2, 6'h00, w);
    wait_drain();
    check("illegal_proto_err", 32'(proto_err), 32'd0);

    // spurious ALU result valid
    inject = 1'b1;
    @(posedge clk);
    #1;
    inject = 1'b0;
    @(negedge clk);
    check("fault_proto_err", 32'(proto_err), 32'd1);
    check("fault_no_push", 32'(resp_vld), 32'd0);
    repeat (5) @(negedge clk);
    check("fault_proto_sticky", 32'(proto_err), 32'd1);
    @(posedge clk);
    #1;

    // reset with one stored result and two in flight
    resp_rdy = 1'b0;
    send(2'd1, 6'h01, 6'h02, 4'd1, 6'h03, w);
    repeat (4) @(posedge clk);
    #1;
    send(2'd1, 6'h04, 6'h05, 4'd6, 6'h09, w);
    send(2'd2, 6'h09, 6'h01, 4'd7, 6'h08, w);
    rst = 1'b1;
    exp_q.delete();
    req_vld = 1'b1;
    @(negedge clk);
    check("mid_rst_req_rdy",   32'(req_rdy),   32'd0);
    check("mid_rst_alu_vld",   32'(alu_vld),   32'd0);
    check("mid_rst_resp_vld",  32'(resp_vld),  32'd0);
    check("mid_rst_resp_data", 32'(resp_data), 32'd0);
    check("mid_rst_resp_tag",  32'(resp_tag),  32'd0);
    check("mid_rst_resp_err",  32'(resp_err),  32'd0);
    check("mid_rst_proto_err", 32'(proto_err), 32'd0);
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    check("mid_rst_rdy_back", 32'(req_rdy), 32'd1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_vld) bad++;
    end
    check("mid_rst_no_resp", 32'(bad), 32'd0);
    check("mid_rst_proto_clear", 32'(proto_err), 32'd0);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
